logic_reduce_seq_v: RTL and testbench

- Parametrised, sequential successor to the fixed 4-input OR gate.
- Accepts a programmable number of WIDTH-bit input beats under a valid/ready handshake.
- Accumulates the beats bitwise with a selectable operator (OR/AND/XOR/NOR), then presents a per-column result vector plus a single reduced bit under an output handshake.
- Sits between stimulus/datapath sources and downstream checkers as a generic reduction engine.

---
 rtl/logic_reduce_pkg.sv | 16 +
 rtl/logic_op_unit_v.sv | 39 +++
 rtl/logic_reduce_seq_v.sv | 119 +++++++++++
 tb/tb_logic_reduce_seq_v.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/logic_reduce_pkg.sv
// Shared constants for the sequential bitwise reduction engine.
// Operator codes and FSM state encoding.
package logic_reduce_pkg;

   localparam logic [1:0] MODE_OR  = 2'b00;
   localparam logic [1:0] MODE_AND = 2'b01;
   localparam logic [1:0] MODE_XOR = 2'b10;
   localparam logic [1:0] MODE_NOR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/logic_op_unit_v.sv
// Combinational operator datapath: folds one beat into the accumulator and
// derives the final column vector / reduced bit from the folded value.
module logic_op_unit_v
   import logic_reduce_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_acc_nxt,
   output logic [WIDTH-1:0] o_col,
   output logic             o_f
);

   always_comb begin
      o_acc_nxt = i_acc ^ i_data;
      case (i_mode)
         MODE_OR, MODE_NOR: o_acc_nxt = i_acc | i_data;
         MODE_AND:          o_acc_nxt = i_acc & i_data;
         default:           o_acc_nxt = i_acc ^ i_data;
      endcase
   end

   // Finalisation looks at the post-beat value so the result can be
   // registered on the same edge that accepts the last beat.
   always_comb begin
      o_col = o_acc_nxt;
      o_f   = |o_acc_nxt;
      case (i_mode)
         MODE_OR:  begin o_col = o_acc_nxt;  o_f = |o_acc_nxt;  end
         MODE_AND: begin o_col = o_acc_nxt;  o_f = &o_acc_nxt;  end
         MODE_XOR: begin o_col = o_acc_nxt;  o_f = ^o_acc_nxt;  end
         MODE_NOR: begin o_col = ~o_acc_nxt; o_f = ~|o_acc_nxt; end
         default:  begin o_col = o_acc_nxt;  o_f = |o_acc_nxt;  end
      endcase
   end

endmodule

// File: rtl/logic_reduce_seq_v.sv
// Sequential reduction engine: accepts a programmable number of beats,
// folds them with OR/AND/XOR/NOR and presents the result under a handshake.
module logic_reduce_seq_v
   import logic_reduce_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_BEATS = 16,
   parameter int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [BEAT_W-1:0] i_beats,
   input  logic              i_valid,
   input  logic [WIDTH-1:0]  i_data,
   output logic              o_ready,
   output logic              o_valid,
   input  logic              i_out_ready,
   output logic [WIDTH-1:0]  o_col,
   output logic              o_f,
   output logic              o_busy,
   output logic [BEAT_W-1:0] o_beat_cnt
);

   localparam logic [BEAT_W-1:0] MAX_B = BEAT_W'(MAX_BEATS);
   localparam logic [BEAT_W-1:0] ONE_B = BEAT_W'(1);

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [BEAT_W-1:0] beats_q, beats_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  col_q, col_d;
   logic              f_q, f_d;

   logic [BEAT_W-1:0] eff_beats;
   logic [BEAT_W-1:0] cnt_inc;
   logic [WIDTH-1:0]  acc_nxt;
   logic [WIDTH-1:0]  col_nxt;
   logic              f_nxt;

   assign eff_beats = (i_beats == '0)   ? ONE_B :
                      (i_beats > MAX_B) ? MAX_B : i_beats;
   assign cnt_inc   = cnt_q + ONE_B;

   logic_op_unit_v #(.WIDTH(WIDTH)) u_op (
      .i_mode    (mode_q),
      .i_acc     (acc_q),
      .i_data    (i_data),
      .o_acc_nxt (acc_nxt),
      .o_col     (col_nxt),
      .o_f       (f_nxt)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      beats_d = beats_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      col_d   = col_q;
      f_d     = f_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               mode_d  = i_mode;
               beats_d = eff_beats;
               acc_d   = (i_mode == MODE_AND) ? '1 : '0;
               cnt_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (i_valid) begin
               acc_d = acc_nxt;
               cnt_d = cnt_inc;
               if (cnt_inc == beats_q) begin
                  col_d   = col_nxt;
                  f_d     = f_nxt;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (i_out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_OR;
         beats_q <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         col_q   <= '0;
         f_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         beats_q <= beats_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         col_q   <= col_d;
         f_q     <= f_d;
      end
   end

   assign o_ready    = (state_q == ST_ACCUM);
   assign o_valid    = (state_q == ST_DONE);
   assign o_busy     = (state_q != ST_IDLE);
   assign o_col      = col_q;
   assign o_f        = f_q;
   assign o_beat_cnt = cnt_q;

endmodule

// File: tb/tb_logic_reduce_seq_v.sv
// Directed + randomized bench for logic_reduce_seq_v (WIDTH=4, MAX_BEATS=16)
// against a per-column counting reference model.
module tb_logic_reduce_seq_v;

   localparam int WIDTH     = 4;
   localparam int MAX_BEATS = 16;
   localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_start = 1'b0;
   logic [1:0]        i_mode = '0;
   logic [BEAT_W-1:0] i_beats = '0;
   logic              i_valid = 1'b0;
   logic [WIDTH-1:0]  i_data = '0;
   logic              o_ready, o_valid, o_f, o_busy;
   logic              i_out_ready = 1'b0;
   logic [WIDTH-1:0]  o_col;
   logic [BEAT_W-1:0] o_beat_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] beats_a [0:31];

   always #5 i_clk = ~i_clk;

   logic_reduce_seq_v #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
      .i_beats(i_beats), .i_valid(i_valid), .i_data(i_data),
      .o_ready(o_ready), .o_valid(o_valid), .i_out_ready(i_out_ready),
      .o_col(o_col), .o_f(o_f), .o_busy(o_busy), .o_beat_cnt(o_beat_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: count ones per column over n beats and decide from the count.
   function automatic logic [WIDTH:0] model(input logic [1:0] m, input int n);
      logic [WIDTH-1:0] col;
      logic             f;
      for (int c = 0; c < WIDTH; c++) begin
         int ones = 0;
         for (int b = 0; b < n; b++) ones += int'(beats_a[b][c]);
         case (m)
            2'b00:   col[c] = (ones > 0);
            2'b01:   col[c] = (ones == n);
            2'b10:   col[c] = (ones % 2 == 1);
            default: col[c] = (ones == 0);
         endcase
      end
      case (m)
         2'b00:   f = (col != '0);
         2'b01:   f = (col == '1);
         2'b10:   f = ^col;
         default: f = (col == '1);
      endcase
      return {f, col};
   endfunction

   function automatic int eff(input logic [BEAT_W-1:0] nb);
      if (nb == 0) return 1;
      if (nb > MAX_BEATS) return MAX_BEATS;
      return int'(nb);
   endfunction

   task automatic run_op(input logic [1:0] m, input logic [BEAT_W-1:0] nb,
                         input bit gaps, input int hold);
      int n, k, cyc;
      logic [WIDTH:0] exp;
      logic [WIDTH-1:0] col_seen;
      n   = eff(nb);
      exp = model(m, n);
      @(negedge i_clk);
      i_start = 1'b1; i_mode = m; i_beats = nb;
      @(negedge i_clk);
      i_start = 1'b0; i_mode = 2'($urandom); i_beats = BEAT_W'($urandom);
      check("accum_busy", o_busy, 1);
      check("accum_ready", o_ready, 1);
      check("accum_cnt0", o_beat_cnt, 0);
      k = 0; cyc = 0;
      while (k < n && cyc < 200) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            i_valid = 1'b0; i_data = 4'($urandom);
         end else begin
            i_valid = 1'b1; i_data = beats_a[k];
         end
         @(negedge i_clk);
         cyc++;
         if (i_valid) k++;
         check("beat_cnt", o_beat_cnt, k);
         check("valid_timing", o_valid, (k == n));
      end
      if (k < n) check("beat_timeout", 0, 1);
      check("done_col", o_col, exp[WIDTH-1:0]);
      check("done_f", o_f, exp[WIDTH]);
      check("done_ready", o_ready, 0);
      // Backpressure: extra beats and start pulses must be ignored.
      col_seen = o_col;
      for (int h = 0; h < hold; h++) begin
         i_valid = 1'b1; i_data = 4'($urandom); i_start = h[0];
         @(negedge i_clk);
         check("hold_valid", o_valid, 1);
         check("hold_col", o_col, col_seen);
         check("hold_cnt", o_beat_cnt, n);
      end
      i_valid = 1'b0; i_start = 1'b0; i_out_ready = 1'b1;
      @(negedge i_clk);
      i_out_ready = 1'b0;
      check("post_valid", o_valid, 0);
      check("post_busy", o_busy, 0);
      check("post_col", o_col, exp[WIDTH-1:0]);
      check("post_f", o_f, exp[WIDTH]);
   endtask

   initial begin
      // Reset
      repeat (2) @(negedge i_clk);
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 0);
      check("rst_busy", o_busy, 0);
      check("rst_col", o_col, 0);
      check("rst_f", o_f, 0);
      check("rst_cnt", o_beat_cnt, 0);
      i_rst = 1'b0;

      // OR single beat, all 16 values
      for (int v = 0; v < 16; v++) begin
         beats_a[0] = 4'(v);
         run_op(2'b00, 5'd1, 1'b0, 0);
      end

      // AND with gaps
      beats_a[0] = 4'b1111; beats_a[1] = 4'b1011; beats_a[2] = 4'b1110;
      run_op(2'b01, 5'd3, 1'b1, 1);

      // XOR and NOR
      beats_a[0] = 4'b1100; beats_a[1] = 4'b1010;
      run_op(2'b10, 5'd2, 1'b0, 0);
      beats_a[0] = 4'b0000; beats_a[1] = 4'b0000;
      run_op(2'b11, 5'd2, 1'b0, 0);

      // Backpressure with start pulses
      beats_a[0] = 4'b0110; beats_a[1] = 4'b0011;
      run_op(2'b00, 5'd2, 1'b1, 5);

      // Beat-count boundaries
      beats_a[0] = 4'b0101;
      run_op(2'b10, 5'd0, 1'b0, 2);
      for (int b = 0; b < 16; b++) beats_a[b] = 4'($urandom);
      run_op(2'b01, 5'd20, 1'b1, 2);

      // Reset after 2 of 4 beats
      @(negedge i_clk);
      i_start = 1'b1; i_mode = 2'b01; i_beats = 5'd4;
      @(negedge i_clk);
      i_start = 1'b0; i_valid = 1'b1; i_data = 4'b1010;
      repeat (2) @(negedge i_clk);
      check("mid_cnt", o_beat_cnt, 2);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_ready", o_ready, 0);
      check("mid_rst_cnt", o_beat_cnt, 0);
      check("mid_rst_col", o_col, 0);
      repeat (4) begin
         @(negedge i_clk);
         check("mid_rst_novalid", o_valid, 0);
      end
      i_valid = 1'b0;
      beats_a[0] = 4'b0001;
      run_op(2'b00, 5'd1, 1'b0, 0);

      // Randomized operations
      for (int r = 0; r < 24; r++) begin
         logic [1:0]        m;
         logic [BEAT_W-1:0] nb;
         m  = 2'($urandom);
         nb = BEAT_W'($urandom_range(0, 20));
         for (int b = 0; b < 16; b++) beats_a[b] = 4'($urandom);
         run_op(m, nb, 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
